// File: rtl/mem_access.sv
// mem_access: memory stage of the five-stage RISC-V pipeline.
// Issues aligned loads/stores on a req/ready data bus, steers store lanes,
// extracts and extends load data, times out stuck accesses and holds MEM/WB.
module mem_access #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] MemWriteDataM,
   input  logic [31:0] LUI_or_AUIPCM,
   input  logic [31:0] PCPlus4M,
   input  logic [4:0]  rdM,
   input  logic [2:0]  ResultSrcM,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic        is_loadM,
   input  logic [2:0]  funct3M,
   output logic [31:0] ALUOutM2E,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        mem_stall,
   output logic [31:0] ALUOutW,
   output logic [31:0] ReadDataW,
   output logic [31:0] LUI_or_AUIPCW,
   output logic [31:0] PCPlus4W,
   output logic [4:0]  rdW,
   output logic [2:0]  ResultSrcW,
   output logic        RegWriteW,
   output logic        misalign_W,
   output logic        bus_err_W
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      state, nextState;
   logic [7:0]  waitCnt;
   logic [8:0]  stallsSoFar;
   logic        isAccess, isHalf, isWord, misaligned;
   logic        alignedAccess, abort, complete;
   logic [7:0]  laneByte;
   logic [15:0] laneHalf;
   logic [31:0] loadData;

   // Access decode, alignment check and abort/complete qualification.
   // The IDLE cycle counts as the first stall, so abort fires once
   // TIMEOUT-1 stall cycles have elapsed (TIMEOUT=1 aborts immediately).
   always_comb begin
      isAccess      = is_loadM | MemWriteM;
      isHalf        = (funct3M[1:0] == 2'b01);
      isWord        = funct3M[1];
      misaligned    = isAccess & ((isHalf & ALUOutM[0]) | (isWord & (|ALUOutM[1:0])));
      alignedAccess = isAccess & ~misaligned & ~reset;
      stallsSoFar   = (state == S_WAIT) ? ({1'b0, waitCnt} + 9'd1) : '0;
      abort         = alignedAccess & ~dmem_ready & (stallsSoFar == 9'(TIMEOUT - 1));
      complete      = alignedAccess & dmem_ready;
   end

   // State register and wait counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         waitCnt <= '0;
      end else begin
         state   <= nextState;
         waitCnt <= (state == S_WAIT && nextState == S_WAIT) ? waitCnt + 8'd1 : '0;
      end
   end

   // Next-state logic.
   always_comb begin
      nextState = state;
      case (state)
         S_IDLE: if (alignedAccess && !dmem_ready && !abort) nextState = S_WAIT;
         S_WAIT: if (!alignedAccess || dmem_ready || abort) nextState = S_IDLE;
         default: nextState = S_IDLE;
      endcase
   end

   // Bus outputs, stall, store lane steering and load extraction.
   always_comb begin
      ALUOutM2E = ALUOutM;
      dmem_req  = alignedAccess;
      dmem_we   = alignedAccess & MemWriteM;
      dmem_addr = {ALUOutM[31:2], 2'b00};
      mem_stall = alignedAccess & ~dmem_ready & ~abort;
      case (funct3M[1:0])
         2'b00: begin
            dmem_wdata = {4{MemWriteDataM[7:0]}};
            dmem_wstrb = 4'b0001 << ALUOutM[1:0];
         end
         2'b01: begin
            dmem_wdata = {2{MemWriteDataM[15:0]}};
            dmem_wstrb = 4'b0011 << ALUOutM[1:0];
         end
         default: begin
            dmem_wdata = MemWriteDataM;
            dmem_wstrb = 4'b1111;
         end
      endcase
      if (!MemWriteM) dmem_wstrb = '0;
      laneByte = dmem_rdata[8*ALUOutM[1:0] +: 8];
      laneHalf = ALUOutM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (funct3M)
         3'b000:  loadData = {{24{laneByte[7]}}, laneByte};
         3'b001:  loadData = {{16{laneHalf[15]}}, laneHalf};
         3'b100:  loadData = {24'd0, laneByte};
         3'b101:  loadData = {16'd0, laneHalf};
         default: loadData = dmem_rdata;
      endcase
   end

   // MEM/WB pipeline register: bubble on stall, flags on misalign/abort.
   always_ff @(posedge clk) begin
      if (reset) begin
         ALUOutW       <= '0;
         ReadDataW     <= '0;
         LUI_or_AUIPCW <= '0;
         PCPlus4W      <= '0;
         rdW           <= '0;
         ResultSrcW    <= '0;
         RegWriteW     <= 1'b0;
         misalign_W    <= 1'b0;
         bus_err_W     <= 1'b0;
      end else if (mem_stall) begin
         RegWriteW  <= 1'b0;
         misalign_W <= 1'b0;
         bus_err_W  <= 1'b0;
      end else begin
         ALUOutW       <= ALUOutM;
         ReadDataW     <= (is_loadM && complete) ? loadData : '0;
         LUI_or_AUIPCW <= LUI_or_AUIPCM;
         PCPlus4W      <= PCPlus4M;
         rdW           <= rdM;
         ResultSrcW    <= ResultSrcM;
         RegWriteW     <= RegWriteM & ~misaligned & ~abort;
         misalign_W    <= misaligned;
         bus_err_W     <= abort;
      end
   end

endmodule
